hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have parameter TIMEOUT, default 16, dmem_busy cycles before err_timeout is raised.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, bubble cycles needed to empty D/E/M/W.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have ports Rs1D, Rs2D  input  5 each  source register fields of the instruction in decode.
REQ-007 SHALL have port RdE  input  5  destination register of the instruction in execute.
REQ-008 SHALL have port MemReadE  input  1  execute-stage instruction is a load.
REQ-009 SHALL have port PCSrcM  input  1  taken branch/jump registered in EX/MEM; PC redirect this cycle.
REQ-010 SHALL have port dmem_busy  input  1  data memory cannot complete the MEM-stage access this cycle.
REQ-011 SHALL have port halt_req  input  1  request to drain and hold the pipeline.
REQ-012 SHALL have outputs stall_F, stall_D, stall_E, stall_M  output  1 each  hold PC / IF_ID / ID_EX / EX_MEM.
REQ-013 SHALL have outputs flush_D, flush_E, flush_M, flush_W  output  1 each  load bubble into IF_ID / ID_EX / EX_MEM / MEM_WB.
REQ-014 SHALL have outputs halted, err_timeout  output  1 each, and state  output  2.
REQ-015 SHALL have outputs stall_cycles, flush_events  output  CNT_W each.

Function
REQ-016 SHALL implement FSM RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, exposed on state.
REQ-017 SHALL drive stall/flush outputs combinationally from state and current inputs (Mealy); all are 0 unless listed.
REQ-018 SHALL define load_use = MemReadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-019 SHALL, in RUN, apply priority dmem_busy > PCSrcM > load_use > halt_req.
REQ-020 SHALL, on dmem_busy in RUN/MEM_WAIT/DRAIN, assert stall_F, stall_D, stall_E, stall_M, flush_W; go/stay MEM_WAIT; PCSrcM and load_use ignored that cycle.
REQ-021 SHALL, on PCSrcM without busy, deassert stall_F (PC loads target) and assert flush_D, flush_E, flush_M for that one cycle.
REQ-022 SHALL, on load_use alone in RUN, assert stall_F, stall_D, flush_E for one cycle; remain RUN.
REQ-023 SHALL, on halt_req alone in RUN, enter DRAIN with drain_cnt=0; outputs that cycle as in RUN with no hazard.
REQ-024 SHALL, in DRAIN without busy/PCSrcM, assert stall_F, flush_D; drain_cnt++; at drain_cnt==DRAIN_CYCLES-1 go HALTED.
REQ-025 SHALL, on PCSrcM in DRAIN, apply REQ-021 and clear drain_cnt to 0; load_use is ignored in DRAIN.
REQ-026 SHALL, in MEM_WAIT, count wait_cnt per busy cycle; when wait_cnt reaches TIMEOUT set err_timeout (sticky until reset).
REQ-027 SHALL leave MEM_WAIT on dmem_busy=0 to DRAIN if a drain was in progress (drain_cnt retained), else RUN; wait_cnt cleared; inputs that cycle evaluated per target state.
REQ-028 SHALL, in HALTED, assert stall_F, flush_D, halted; on halt_req=0 return to RUN next cycle.
REQ-029 SHALL increment stall_cycles every cycle stall_F=1, and flush_events once per cycle PCSrcM causes a flush; both saturate at all-ones.

Reset
REQ-030 SHALL on rst=1 set state=RUN, drain_cnt=0, wait_cnt=0, err_timeout=0, stall_cycles=0, flush_events=0, halted=0.
REQ-031 SHALL, while rst=1, drive all stall_* and flush_* outputs 0; reset mid-DRAIN/MEM_WAIT returns to RUN next edge.

Verification
REQ-032 SHALL cover load-use: MemReadE=1, RdE=5, Rs2D=5 -> stall_F=stall_D=flush_E=1 one cycle, stall_cycles=1.
REQ-033 SHALL cover RdE=0 with MemReadE=1, Rs1D=0 -> no stall.
REQ-034 SHALL cover branch: PCSrcM=1 one cycle -> flush_D/E/M=1, stall_F=0, flush_events=1.
REQ-035 SHALL cover busy+PCSrcM: dmem_busy=1 for 20 cycles, TIMEOUT=16 -> freeze outputs, no flush, state=1, err_timeout=1 after 16th busy cycle.
REQ-036 SHALL cover halt: halt_req=1 -> DRAIN 4 cycles, then halted=1, state=3; halt_req=0 -> RUN next cycle.
REQ-037 SHALL cover rst=1 in DRAIN cycle 2 -> state=0, counters=0, all stall/flush outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, memory-wait freeze
// and halt/drain sequencing, plus saturating stall/flush performance counters.
`timescale 1ns/1ps
module hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcM,
    input  logic             dmem_busy,
    input  logic             halt_req,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             flush_W,
    output logic             halted,
    output logic             err_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);

    state_t           r_state;
    state_t           w_evalState;
    state_t           w_nextState;
    logic [DW-1:0]    r_drainCnt;
    logic [DW-1:0]    w_nextDrainCnt;
    logic [WW-1:0]    r_waitCnt;
    logic             r_drainPending;
    logic             r_errTimeout;
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushEvents;
    logic             w_loadUse;
    logic             w_branchFlush;

    assign w_loadUse = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // The cycle memory stops being busy is handled as if already back in the
    // state we are returning to, so its hazards are honoured immediately.
    always_comb begin
        w_evalState = r_state;
        if (r_state == MEM_WAIT && !dmem_busy)
            w_evalState = r_drainPending ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_drainCnt     <= '0;
            r_drainPending <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_drainCnt <= w_nextDrainCnt;
            if (w_evalState != MEM_WAIT)
                r_drainPending <= (w_evalState == DRAIN);
        end
    end

    always_comb begin
        w_nextState    = w_evalState;
        w_nextDrainCnt = r_drainCnt;
        case (w_evalState)
            RUN: begin
                if (dmem_busy)
                    w_nextState = MEM_WAIT;
                else if (!PCSrcM && !w_loadUse && halt_req) begin
                    w_nextState    = DRAIN;
                    w_nextDrainCnt = '0;
                end
            end
            DRAIN: begin
                if (dmem_busy)
                    w_nextState = MEM_WAIT;
                else if (PCSrcM)
                    w_nextDrainCnt = '0;
                else if (r_drainCnt == DRAIN_LAST)
                    w_nextState = HALTED;
                else
                    w_nextDrainCnt = r_drainCnt + DW'(1);
            end
            MEM_WAIT: w_nextState = MEM_WAIT;
            HALTED:   w_nextState = halt_req ? HALTED : RUN;
            default:  w_nextState = RUN;
        endcase
    end

    always_comb begin
        stall_F       = 1'b0;
        stall_D       = 1'b0;
        stall_E       = 1'b0;
        stall_M       = 1'b0;
        flush_D       = 1'b0;
        flush_E       = 1'b0;
        flush_M       = 1'b0;
        flush_W       = 1'b0;
        halted        = 1'b0;
        w_branchFlush = 1'b0;
        if (!rst) begin
            case (w_evalState)
                RUN, DRAIN, MEM_WAIT: begin
                    if (dmem_busy) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        stall_E = 1'b1;
                        stall_M = 1'b1;
                        flush_W = 1'b1;
                    end else if (PCSrcM) begin
                        flush_D       = 1'b1;
                        flush_E       = 1'b1;
                        flush_M       = 1'b1;
                        w_branchFlush = 1'b1;
                    end else if (w_evalState == RUN && w_loadUse) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (w_evalState == DRAIN) begin
                        stall_F = 1'b1;
                        flush_D = 1'b1;
                    end
                end
                HALTED: begin
                    stall_F = 1'b1;
                    flush_D = 1'b1;
                    halted  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Busy cycles are counted from the first one; the error latches on the
    // TIMEOUT-th and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt    <= '0;
            r_errTimeout <= 1'b0;
        end else if (dmem_busy && w_evalState != HALTED) begin
            if (r_waitCnt != WAIT_LIMIT)
                r_waitCnt <= r_waitCnt + WW'(1);
            if (r_waitCnt == WAIT_LIMIT - WW'(1))
                r_errTimeout <= 1'b1;
        end else begin
            r_waitCnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            if (stall_F && r_stallCycles != '1)
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            if (w_branchFlush && r_flushEvents != '1)
                r_flushEvents <= r_flushEvents + CNT_W'(1);
        end
    end

    assign state        = r_state;
    assign err_timeout  = r_errTimeout;
    assign stall_cycles = r_stallCycles;
    assign flush_events = r_flushEvents;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push their
// hand-computed expectations; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hazard_ctrl;

   localparam int CNT_W = 16;

   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_LU   = 8'b1100_0100;
   localparam logic [7:0] C_BR   = 8'b0000_1110;
   localparam logic [7:0] C_BUSY = 8'b1111_0001;
   localparam logic [7:0] C_DRN  = 8'b1000_1000;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       Rs1D, Rs2D, RdE;
   logic             MemReadE, PCSrcM, dmem_busy, halt_req;
   logic             stall_F, stall_D, stall_E, stall_M;
   logic             flush_D, flush_E, flush_M, flush_W;
   logic             halted, err_timeout;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   typedef struct packed {
      logic [7:0]       ctl;
      logic [1:0]       st;
      logic             hlt;
      logic             err;
      logic [CNT_W-1:0] stalls;
      logic [CNT_W-1:0] flushes;
   } exp_t;

   exp_t expQ[$];
   int   tagQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   vecNum   = 0;

   // Ten-unit clock period
   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(16), .DRAIN_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
      .MemReadE(MemReadE), .PCSrcM(PCSrcM), .dmem_busy(dmem_busy), .halt_req(halt_req),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
      .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
      .halted(halted), .err_timeout(err_timeout), .state(state),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   // Drives one cycle's inputs just after the edge and queues what that
   // cycle must look like (combinational outputs plus registered state).
   task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr, input logic pc,
                                input logic busy, input logic halt, input logic [7:0] eCtl,
                                input logic [1:0] eSt, input logic eHlt, input logic eErr,
                                input int eStalls, input int eFlushes);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      Rs1D      = rs1;
      Rs2D      = rs2;
      RdE       = rd;
      MemReadE  = mr;
      PCSrcM    = pc;
      dmem_busy = busy;
      halt_req  = halt;
      e.ctl     = eCtl;
      e.st      = eSt;
      e.hlt     = eHlt;
      e.err     = eErr;
      e.stalls  = eStalls[CNT_W-1:0];
      e.flushes = eFlushes[CNT_W-1:0];
      expQ.push_back(e);
      tagQ.push_back(vecNum);
      vecNum++;
   endtask

   task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                              input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL vec%0d %s actual=%0h required=%0h", tag, name, act, req);
      end
   endtask

   // Monitor: compares the oldest pending expectation mid-cycle
   always @(negedge clk) begin
      exp_t e;
      int   t;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         t = tagQ.pop_front();
         checkOutput("ctl", t, 32'({stall_F, stall_D, stall_E, stall_M,
                                    flush_D, flush_E, flush_M, flush_W}), 32'(e.ctl));
         checkOutput("state", t, 32'(state), 32'(e.st));
         checkOutput("halted", t, 32'(halted), 32'(e.hlt));
         checkOutput("err_timeout", t, 32'(err_timeout), 32'(e.err));
         checkOutput("stall_cycles", t, 32'(stall_cycles), 32'(e.stalls));
         checkOutput("flush_events", t, 32'(flush_events), 32'(e.flushes));
      end
   end

   initial begin
      int guard;
      rst = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0;
      MemReadE = 1'b0; PCSrcM = 1'b0; dmem_busy = 1'b0; halt_req = 1'b0;
      @(posedge clk);
      // Reset held with every hazard input active: outputs must stay quiet
      applyStimulus(1, 5, 5, 5, 1, 1, 1, 1, C_NONE, 0, 0, 0, 0, 0);
      // Load-use and the register-zero exception
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5, 5, 1, 0, 0, 0, C_LU,   0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, C_NONE, 0, 0, 0, 1, 0);
      applyStimulus(0, 7, 3, 7, 1, 0, 0, 0, C_LU,   0, 0, 0, 1, 0);
      applyStimulus(0, 7, 3, 7, 0, 0, 0, 0, C_NONE, 0, 0, 0, 2, 0);
      // Branch alone, then branch beating a simultaneous load-use
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, C_BR,   0, 0, 0, 2, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 2, 1);
      applyStimulus(0, 1, 5, 5, 1, 1, 0, 0, C_BR,   0, 0, 0, 2, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 2, 2);
      // Twenty busy cycles with a branch pending: freeze, timeout after the 16th
      for (int k = 1; k <= 20; k++)
         applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, C_BUSY, (k == 1) ? 2'd0 : 2'd1, 0,
                       (k >= 17) ? 1'b1 : 1'b0, k + 1, 2);
      // Busy drops while branch still asserted: flush taken on the exit cycle
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, C_BR,   1, 0, 1, 22, 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 1, 22, 3);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 1, 22, 3);
      // Halt: one RUN cycle, four DRAIN cycles, HALTED, release
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 2, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 3, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  3, 1, 0, 4, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_DRN,  3, 1, 0, 5, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 6, 0);
      // Drain interrupted by a branch (restart) and by a busy spell (resume)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 0, 0, 0, 6, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 6, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, C_BR,   2, 0, 0, 7, 0);
      applyStimulus(0, 1, 5, 5, 1, 0, 0, 1, C_DRN,  2, 0, 0, 7, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, C_BUSY, 2, 0, 0, 8, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  1, 0, 0, 9, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 10, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 11, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_DRN,  3, 1, 0, 12, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 13, 1);
      // Reset during the second DRAIN cycle
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 0, 0, 0, 13, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, C_DRN,  2, 0, 0, 13, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2, 0, 0, 14, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0, 0);

      guard = 0;
      while (expQ.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (expQ.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_queue actual=%0d pending required=0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
